// File: rtl/reg_transfer_sequencer.sv
// Register transfer sequencer: executes MOV / LDI / SWAP / CLR commands
// against an external register file through one read port (loadselector /
// loadbus) and one write port (save / saveselector / savebus).
//
// Handshake: a command is taken on a rising clock edge where cmdvalid=1 and
// cmdready=1. cmdready is high only in IDLE while reset is released, so
// cmdvalid held high in any other state is simply ignored. All cmd* fields
// are captured at that edge and the inputs are not looked at again until the
// sequencer is back in IDLE.
module reg_transfer_sequencer #(
  parameter int WIDTH   = 8,
  parameter int NUMREGS = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmdvalid,
  output logic             cmdready,
  input  logic [1:0]       cmdop,
  input  logic [2:0]       cmdsrc,
  input  logic [2:0]       cmddst,
  input  logic [WIDTH-1:0] cmdimm,
  output logic             save,
  output logic [2:0]       saveselector,
  output logic [WIDTH-1:0] savebus,
  output logic [2:0]       loadselector,
  input  logic [WIDTH-1:0] loadbus,
  output logic             done,
  output logic             error,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ1  = 3'd1,
    READ2  = 3'd2,
    WRITE1 = 3'd3,
    WRITE2 = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // One extra bit so NUMREGS=8 (every selector valid) still compares correctly.
  localparam logic [3:0] NUMREGS_L = 4'(NUMREGS);

  state_t           state;
  logic [1:0]       op_q;
  logic [2:0]       src_q;
  logic [2:0]       dst_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] tempa;
  logic [WIDTH-1:0] tempb;
  logic             err_q;

  logic dst_bad;
  logic src_bad;
  logic uses_src;
  logic cmd_bad;

  // Selector validation of the incoming command; src only matters for reads.
  always_comb begin
    dst_bad  = ({1'b0, cmddst} >= NUMREGS_L);
    src_bad  = ({1'b0, cmdsrc} >= NUMREGS_L);
    uses_src = (cmdop == OP_MOV) || (cmdop == OP_SWAP);
    cmd_bad  = dst_bad || (uses_src && src_bad);
  end

  // Sequencer FSM: command capture, read staging into tempa/tempb, sequencing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= 2'b00;
      src_q <= 3'd0;
      dst_q <= 3'd0;
      imm_q <= '0;
      tempa <= '0;
      tempb <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmdvalid) begin
            op_q  <= cmdop;
            src_q <= cmdsrc;
            dst_q <= cmddst;
            imm_q <= cmdimm;
            err_q <= cmd_bad;
            if (cmd_bad) begin
              // Rejected commands skip straight to FINISH with no register access.
              state <= FINISH;
            end else begin
              case (cmdop)
                OP_MOV, OP_SWAP: state <= READ1;
                default:         state <= WRITE1;
              endcase
            end
          end
        end
        READ1: begin
          tempa <= loadbus;
          state <= (op_q == OP_SWAP) ? READ2 : WRITE1;
        end
        READ2: begin
          tempb <= loadbus;
          state <= WRITE1;
        end
        WRITE1: begin
          state <= (op_q == OP_SWAP) ? WRITE2 : FINISH;
        end
        WRITE2: begin
          state <= FINISH;
        end
        FINISH: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state; idle outputs are held at zero.
  always_comb begin
    cmdready     = 1'b0;
    save         = 1'b0;
    saveselector = 3'd0;
    savebus      = '0;
    loadselector = 3'd0;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so cmdready is low while reset is held.
        cmdready = reset;
      end
      READ1: begin
        loadselector = src_q;
      end
      READ2: begin
        loadselector = dst_q;
      end
      WRITE1: begin
        save         = 1'b1;
        saveselector = dst_q;
        case (op_q)
          OP_LDI:  savebus = imm_q;
          OP_CLR:  savebus = '0;
          default: savebus = tempa;
        endcase
      end
      WRITE2: begin
        save         = 1'b1;
        saveselector = src_q;
        savebus      = tempb;
      end
      FINISH: begin
        done  = 1'b1;
        error = err_q;
      end
      default: begin
        cmdready = 1'b0;
      end
    endcase
  end

  // Debug view of the FSM state.
  always_comb begin
    dbg_state = state;
  end

endmodule
